hd44780_responder: RTL and testbench
====================================

# hd44780_responder

Synthesizable responder for the SC1602/HD44780 parallel bus; the device-side counterpart of our LCD driver. It samples E/RS/RW/DB[7:4], assembles bytes in 8-bit or 4-bit mode, and executes the core command set against an internal 128-byte DDRAM. It models the busy timer and, when compiled in, answers busy-flag and data reads. It sits in loopback test tops and on a second board header, so driver RTL can be exercised without a physical display.

## Interface
- SYNC_STAGES, 2: flops in the E/RS/RW/DB synchronizer (≥2).
- BUSY_CYCLES, 1000: busy duration for ordinary commands and data writes (~37 µs at 27 MHz).
- CLEAR_CYCLES, 41000: busy duration for clear/home (~1.52 ms at 27 MHz); must be ≥128.
- sys_clk  in  1  system clock.
- sys_rst_n  in  1  asynchronous, active-low reset.
- lcd_e  in  1  bus enable, asynchronous to sys_clk.
- lcd_rs  in  1  register select: 0 = instruction, 1 = data.
- lcd_rw  in  1  1 = read.
- lcd_d_in  in  4  DB[7:4] input.
- lcd_d_out  out  4  DB[7:4] read data.
- lcd_d_oe  out  1  output enable for lcd_d_out.
- cmd_valid  out  1  one-cycle strobe per assembled write byte.
- cmd_rs  out  1  RS of that byte.
- cmd_byte  out  8  assembled byte.
- busy  out  1  busy flag.
- ac  out  7  address counter.
- err_busy  out  1  sticky flag: a write completed while busy.
- disp_addr  in  7  DDRAM scan address.
- disp_data  out  8  DDRAM[disp_addr], registered.

## Operation
- Reset values: all outputs 0; mode ST_8BIT; I/D = 1 (increment). DDRAM contents are not reset.
- Bus sampling:
  - All bus inputs pass through the SYNC_STAGES synchronizer.
  - A write is a detected falling edge of synced E with synced RW = 0. The nibble is the synced lcd_d_in at that edge.
- Mode state machine:
  - ST_8BIT: each write is one byte {nibble, 4'h0}.
  - ST_HI: a write stores the high nibble and moves to ST_LO.
  - ST_LO: a write completes the byte and returns to ST_HI.
- Mode switching by function set (byte[7:5] = 3'b001):
  - DL = 0 (byte[4]) moves to ST_HI.
  - DL = 1 moves to ST_8BIT.
- Byte completion:
  - Strobe cmd_valid with cmd_rs/cmd_byte.
  - If not busy, execute the byte. If busy, do not execute it; set err_busy (cleared only by reset). It is still strobed.
- Execution:
  - RS = 1: DDRAM[ac] ← byte; ac ← ac ± 1 per I/D (7-bit wrap, 0x7F+1 → 0x00, 0x00−1 → 0x7F); busy for BUSY_CYCLES.
  - 0x01 clear: ac ← 0, I/D ← 1, busy for CLEAR_CYCLES. A sweep writes 0x20 to DDRAM[0..127], one entry per cycle, starting the cycle after execution.
  - 0x02/0x03 home: ac ← 0, busy for CLEAR_CYCLES.
  - 0x04–0x07 entry mode: I/D ← byte[1], busy for BUSY_CYCLES.
  - byte[7] = 1 (set DDRAM address): ac ← byte[6:0], busy for BUSY_CYCLES.
  - All other instructions (display control, shift, function set, CGRAM address): no state change beyond busy for BUSY_CYCLES.
- Reads (RW = 1), with the read feature compiled in:
  - lcd_d_oe follows synced (E & RW).
  - RS = 0 returns {busy, ac}. RS = 1 returns DDRAM[ac].
  - In ST_8BIT only the high nibble is returned, and each falling edge counts as a complete read.
  - In 4-bit mode the first pulse returns the high nibble and the second the low nibble; reads share the ST_HI/ST_LO phase.
  - A completed data read (RS = 1) advances ac per I/D. Reads are serviced even while busy.
- Reset mid-operation aborts any clear sweep and busy count and returns to ST_8BIT.

## Timing
- Bus to internal: SYNC_STAGES cycles. Falling-edge detect adds 1 cycle. cmd_valid is asserted on the following cycle.
- Execution and busy rise occur in the same cycle as cmd_valid. busy falls exactly BUSY_CYCLES or CLEAR_CYCLES cycles later.
- lcd_d_oe/lcd_d_out are valid SYNC_STAGES+1 cycles after E rises, and drop the same latency after E falls.
- disp_data has 1-cycle latency. The scan port is read-only; it has no conflict with writes.
- A write completing in the same cycle that busy falls is treated as not busy.

## Configuration
- HD44780_RSP_READ_EN defined: the read path is present as described.
- HD44780_RSP_READ_EN undefined:
  - lcd_d_oe and lcd_d_out are tied to 0.
  - RW = 1 pulses are ignored: they do not advance the nibble phase and do not change ac.

## Structure
- Package hd44780_pkg holds:
  - mode enum (ST_8BIT, ST_HI, ST_LO);
  - command opcodes/masks (CMD_CLEAR, CMD_HOME, CMD_ENTRY, CMD_FUNC, CMD_DDRAM);
  - DDRAM_DEPTH = 128;
  - BLANK_CHAR = 8'h20.
- Sub-module lcd_bus_sync holds the synchronizer plus E rise/fall pulse generation.

## Test plan
- Reset → all outputs 0, busy = 0, ac = 0x00; a single 8-bit write of nibble 0x3 → cmd_byte 0x30, cmd_rs 0.
- Init in 8-bit mode with nibbles 0x3, 0x3, 0x3, 0x2 (each after busy clears), then nibbles 0x2, 0x8 → final cmd_byte 0x28; mode is ST_HI.
- In 4-bit mode write RS = 1 nibbles 0x5, 0x2 at ac 0 → DDRAM[0] = 0x52, ac = 0x01, disp_addr 0 → disp_data 0x52 one cycle later.
- Clear (0x0, 0x1) → busy high for CLEAR_CYCLES, ac = 0, all 128 entries = 0x20; a write during busy → err_busy = 1 and no DDRAM change.
- With ac = 0x7F, write one data byte → ac = 0x00. With HD44780_RSP_READ_EN defined and ac = 0x00, read RS = 0 during busy → high nibble 0x8, low nibble 0x0.

Source files
------------

// File: rtl/hd44780_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hd44780_pkg
// Description : Shared types and constants for the HD44780 bus responder:
//               nibble-phase mode encoding, instruction opcodes/masks,
//               DDRAM geometry and the address-counter step helper.
// Revision    : 1.0 - initial release
// ============================================================================
package hd44780_pkg;

  // Byte-assembly phase. ST_HI/ST_LO are the two halves of a 4-bit transfer.
  typedef enum logic [1:0] {
    ST_8BIT = 2'd0,
    ST_HI   = 2'd1,
    ST_LO   = 2'd2
  } mode_t;

  localparam logic [7:0] CMD_CLEAR      = 8'h01;
  localparam logic [7:0] CMD_HOME_MASK  = 8'hFE;
  localparam logic [7:0] CMD_HOME       = 8'h02;
  localparam logic [7:0] CMD_ENTRY_MASK = 8'hFC;
  localparam logic [7:0] CMD_ENTRY      = 8'h04;
  localparam logic [7:0] CMD_FUNC_MASK  = 8'hE0;
  localparam logic [7:0] CMD_FUNC       = 8'h20;
  localparam logic [7:0] CMD_DDRAM_MASK = 8'h80;
  localparam logic [7:0] CMD_DDRAM      = 8'h80;

  localparam int         DDRAM_DEPTH    = 128;
  localparam logic [7:0] BLANK_CHAR     = 8'h20;

  // Address counter moves by one with natural 7-bit wrap in both directions.
  function automatic logic [6:0] ac_step(input logic [6:0] ac_in, input logic inc);
    return inc ? (ac_in + 7'd1) : (ac_in - 7'd1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_bus_sync.sv
`default_nettype none
// ============================================================================
// Module      : lcd_bus_sync
// Description : Synchronizes the asynchronous E/RS/RW/DB[7:4] bus into
//               sys_clk and generates E edge pulses. The falling-edge pulse
//               is registered together with the RS/RW/DB values seen at the
//               edge so the consumer gets one coherent bus event.
// Revision    : 1.0 - initial release
// Ports       : sys_clk, sys_rst_n   clock, async active-low reset
//               lcd_e/rs/rw/d        raw bus inputs
//               e_sync/rs_sync/rw_sync synchronized levels
//               e_rise               combinational, first cycle of synced E high
//               e_fall               registered, one cycle after synced E drops
//               fall_rs/rw/d         bus fields captured with e_fall
// ============================================================================
module lcd_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       lcd_e,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic [3:0] lcd_d,
  output logic       e_sync,
  output logic       rs_sync,
  output logic       rw_sync,
  output logic       e_rise,
  output logic       e_fall,
  output logic       fall_rs,
  output logic       fall_rw,
  output logic [3:0] fall_d
);

  // Packed chain: element 0 is the first flop, SYNC_STAGES-1 the output.
  logic [SYNC_STAGES-1:0][6:0] r_stage;
  logic                        r_e_prev;
  logic [3:0]                  w_d_sync;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_stage <= '0;
    end else begin
      r_stage <= {r_stage[SYNC_STAGES-2:0], {lcd_e, lcd_rs, lcd_rw, lcd_d}};
    end
  end

  assign {e_sync, rs_sync, rw_sync, w_d_sync} = r_stage[SYNC_STAGES-1];
  assign e_rise = e_sync & ~r_e_prev;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_e_prev <= 1'b0;
      e_fall   <= 1'b0;
      fall_rs  <= 1'b0;
      fall_rw  <= 1'b0;
      fall_d   <= 4'h0;
    end else begin
      r_e_prev <= e_sync;
      e_fall   <= ~e_sync & r_e_prev;
      fall_rs  <= rs_sync;
      fall_rw  <= rw_sync;
      fall_d   <= w_d_sync;
    end
  end

endmodule
`default_nettype wire

// File: rtl/hd44780_responder.sv
`default_nettype none
// ============================================================================
// Module      : hd44780_responder
// Description : Device-side model of an SC1602/HD44780 display. Assembles
//               bus writes in 8-bit or 4-bit mode, executes the core command
//               set against a 128-byte DDRAM, models the busy timer and flags
//               writes that land while busy.
// Build macro : HD44780_RSP_READ_EN - when defined, busy-flag/address and
//               DDRAM reads are driven onto lcd_d_out; otherwise the read
//               port is tied off and RW=1 pulses are ignored.
// Revision    : 1.0 - initial release
// Ports       : sys_clk, sys_rst_n      clock, async active-low reset
//               lcd_e/rs/rw/d_in       display bus (async to sys_clk)
//               lcd_d_out, lcd_d_oe    DB[7:4] read drive
//               cmd_valid/rs/byte      strobe per assembled write byte
//               busy, ac, err_busy     status
//               disp_addr, disp_data   read-only DDRAM scan port (1-cycle)
// ============================================================================
module hd44780_responder
  import hd44780_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int BUSY_CYCLES  = 1000,
  parameter int CLEAR_CYCLES = 41000
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       lcd_e,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic [3:0] lcd_d_in,
  output logic [3:0] lcd_d_out,
  output logic       lcd_d_oe,
  output logic       cmd_valid,
  output logic       cmd_rs,
  output logic [7:0] cmd_byte,
  output logic       busy,
  output logic [6:0] ac,
  output logic       err_busy,
  input  logic [6:0] disp_addr,
  output logic [7:0] disp_data
);

  localparam int CNT_MAX = (CLEAR_CYCLES > BUSY_CYCLES) ? CLEAR_CYCLES : BUSY_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] c_busy_load  = CNT_W'(BUSY_CYCLES);
  localparam logic [CNT_W-1:0] c_clear_load = CNT_W'(CLEAR_CYCLES);

  logic       w_e_sync, w_rs_sync, w_rw_sync, w_e_rise;
  logic       w_fall, w_fall_rs, w_fall_rw;
  logic [3:0] w_fall_d;

  mode_t             r_mode, w_mode_next;
  logic [3:0]        r_hi_nib;
  logic [6:0]        r_ac;
  logic              r_id;
  logic [CNT_W-1:0]  r_busy_cnt;
  logic              r_sweep_act;
  logic [6:0]        r_sweep_addr;
  logic [7:0]        r_ddram [DDRAM_DEPTH];

  logic              w_byte_done, w_read_done, w_exec, w_blocked;
  logic [7:0]        w_byte;

  lcd_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .lcd_e     (lcd_e),
    .lcd_rs    (lcd_rs),
    .lcd_rw    (lcd_rw),
    .lcd_d     (lcd_d_in),
    .e_sync    (w_e_sync),
    .rs_sync   (w_rs_sync),
    .rw_sync   (w_rw_sync),
    .e_rise    (w_e_rise),
    .e_fall    (w_fall),
    .fall_rs   (w_fall_rs),
    .fall_rw   (w_fall_rw),
    .fall_d    (w_fall_d)
  );

  assign busy = (r_busy_cnt != '0);
  assign ac   = r_ac;
  // The decision is made the cycle before execution; a count of 1 means busy
  // drops on the very edge this byte executes, so it is accepted.
  assign w_blocked = (r_busy_cnt > CNT_W'(1));

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) r_mode <= ST_8BIT;
    else            r_mode <= w_mode_next;
  end

  always_comb begin
    w_mode_next = r_mode;
    w_byte_done = 1'b0;
    w_read_done = 1'b0;
    w_byte      = {w_fall_d, 4'h0};
    if (w_fall && !w_fall_rw) begin
      case (r_mode)
        ST_8BIT: w_byte_done = 1'b1;
        ST_HI:   w_mode_next = ST_LO;
        default: begin
          w_byte      = {r_hi_nib, w_fall_d};
          w_byte_done = 1'b1;
          w_mode_next = ST_HI;
        end
      endcase
    end
`ifdef HD44780_RSP_READ_EN
    else if (w_fall && w_fall_rw) begin
      case (r_mode)
        ST_8BIT: w_read_done = 1'b1;
        ST_HI:   w_mode_next = ST_LO;
        default: begin
          w_read_done = 1'b1;
          w_mode_next = ST_HI;
        end
      endcase
    end
`endif
    w_exec = w_byte_done && !w_blocked;
    // Function set re-selects the interface width once it actually executes.
    if (w_exec && !w_fall_rs && ((w_byte & CMD_FUNC_MASK) == CMD_FUNC)) begin
      w_mode_next = w_byte[4] ? ST_8BIT : ST_HI;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_hi_nib     <= 4'h0;
      cmd_valid    <= 1'b0;
      cmd_rs       <= 1'b0;
      cmd_byte     <= 8'h00;
      err_busy     <= 1'b0;
      r_ac         <= 7'h00;
      r_id         <= 1'b1;
      r_busy_cnt   <= '0;
      r_sweep_act  <= 1'b0;
      r_sweep_addr <= 7'h00;
    end else begin
      cmd_valid <= w_byte_done;
      if (w_byte_done) begin
        cmd_rs   <= w_fall_rs;
        cmd_byte <= w_byte;
        if (w_blocked) err_busy <= 1'b1;
      end
      if (w_fall && !w_fall_rw && (r_mode == ST_HI)) r_hi_nib <= w_fall_d;

      if (busy) r_busy_cnt <= r_busy_cnt - CNT_W'(1);
      if (r_sweep_act) begin
        r_sweep_addr <= r_sweep_addr + 7'd1;
        if (r_sweep_addr == 7'(DDRAM_DEPTH - 1)) r_sweep_act <= 1'b0;
      end

      // Later assignments override the countdown/sweep updates above.
      if (w_exec) begin
        if (w_fall_rs) begin
          r_ac       <= ac_step(r_ac, r_id);
          r_busy_cnt <= c_busy_load;
        end else if ((w_byte & CMD_DDRAM_MASK) == CMD_DDRAM) begin
          r_ac       <= w_byte[6:0];
          r_busy_cnt <= c_busy_load;
        end else if (w_byte == CMD_CLEAR) begin
          r_ac         <= 7'h00;
          r_id         <= 1'b1;
          r_busy_cnt   <= c_clear_load;
          r_sweep_act  <= 1'b1;
          r_sweep_addr <= 7'h00;
        end else if ((w_byte & CMD_HOME_MASK) == CMD_HOME) begin
          r_ac       <= 7'h00;
          r_busy_cnt <= c_clear_load;
        end else if ((w_byte & CMD_ENTRY_MASK) == CMD_ENTRY) begin
          r_id       <= w_byte[1];
          r_busy_cnt <= c_busy_load;
        end else begin
          r_busy_cnt <= c_busy_load;
        end
      end else if (w_read_done && w_fall_rs) begin
        r_ac <= ac_step(r_ac, r_id);
      end
    end
  end

  // DDRAM contents survive reset; a host write wins over a coincident sweep.
  always_ff @(posedge sys_clk) begin
    if (r_sweep_act) r_ddram[r_sweep_addr] <= BLANK_CHAR;
    if (w_exec && w_fall_rs) r_ddram[r_ac] <= w_byte;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) disp_data <= 8'h00;
    else            disp_data <= r_ddram[disp_addr];
  end

`ifdef HD44780_RSP_READ_EN
  logic [7:0] w_rd_byte;
  logic       w_rd_active;
  logic       w_unused;

  assign w_rd_byte   = w_rs_sync ? r_ddram[r_ac] : {busy, r_ac};
  assign w_rd_active = w_e_sync & w_rw_sync;
  assign w_unused    = w_e_rise;

  // Low nibble only on the second half of a 4-bit read.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      lcd_d_oe  <= 1'b0;
      lcd_d_out <= 4'h0;
    end else begin
      lcd_d_oe  <= w_rd_active;
      lcd_d_out <= !w_rd_active       ? 4'h0 :
                   (r_mode == ST_LO)  ? w_rd_byte[3:0] : w_rd_byte[7:4];
    end
  end
`else
  logic w_unused;
  assign w_unused  = &{1'b0, w_e_rise, w_e_sync, w_rs_sync, w_rw_sync};
  assign lcd_d_oe  = 1'b0;
  assign lcd_d_out = 4'h0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hd44780_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_hd44780_responder
// Description : Directed self-checking bench for hd44780_responder. Runs with
//               or without HD44780_RSP_READ_EN; the read scenario adapts.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hd44780_responder;

  localparam int BUSY  = 40;
  localparam int CLEAR = 150;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       lcd_e = 1'b0, lcd_rs = 1'b0, lcd_rw = 1'b0;
  logic [3:0] lcd_d_in = 4'h0;
  logic [6:0] disp_addr = 7'h00;
  logic [3:0] lcd_d_out;
  logic       lcd_d_oe, cmd_valid, cmd_rs, busy, err_busy;
  logic [7:0] cmd_byte, disp_data;
  logic [6:0] ac;

  hd44780_responder #(.SYNC_STAGES(2), .BUSY_CYCLES(BUSY), .CLEAR_CYCLES(CLEAR)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .lcd_e(lcd_e), .lcd_rs(lcd_rs),
    .lcd_rw(lcd_rw), .lcd_d_in(lcd_d_in), .lcd_d_out(lcd_d_out), .lcd_d_oe(lcd_d_oe),
    .cmd_valid(cmd_valid), .cmd_rs(cmd_rs), .cmd_byte(cmd_byte), .busy(busy),
    .ac(ac), .err_busy(err_busy), .disp_addr(disp_addr), .disp_data(disp_data)
  );

  always #5 sys_clk = ~sys_clk;

  int         n_tests = 0, n_fail = 0;
  int         cyc = 0, n_valid = 0, valid_cyc = 0, fall_cyc = 0;
  logic       prev_busy = 1'b0;
  logic [7:0] last_byte = 8'h00;
  logic       last_rs = 1'b0;

  // Event recorder: strobes and the cycle busy drops.
  always @(negedge sys_clk) begin
    cyc++;
    if (cmd_valid === 1'b1) begin
      n_valid++;
      last_byte = cmd_byte;
      last_rs   = cmd_rs;
      valid_cyc = cyc;
    end
    if (prev_busy === 1'b1 && busy === 1'b0) fall_cyc = cyc;
    prev_busy = busy;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic bus_write(input logic rs, input logic [3:0] nib);
    @(negedge sys_clk); lcd_rs = rs; lcd_rw = 1'b0; lcd_d_in = nib;
    @(negedge sys_clk); lcd_e = 1'b1;
    repeat (4) @(negedge sys_clk);
    lcd_e = 1'b0;
    repeat (6) @(negedge sys_clk);
  endtask

  task automatic bus_read(input logic rs, output logic [3:0] nib, output logic oe);
    @(negedge sys_clk); lcd_rs = rs; lcd_rw = 1'b1;
    @(negedge sys_clk); lcd_e = 1'b1;
    repeat (4) @(negedge sys_clk);
    nib = lcd_d_out;
    oe  = lcd_d_oe;
    @(negedge sys_clk); lcd_e = 1'b0;
    repeat (6) @(negedge sys_clk);
    lcd_rw = 1'b0;
  endtask

  task automatic wait_not_busy();
    int i = 0;
    while (busy === 1'b1 && i < 1000) begin
      @(negedge sys_clk);
      i++;
    end
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_timeout: busy=%b required 0", busy);
    end
    @(negedge sys_clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge sys_clk);
    n_tests++;
    if ({cmd_valid, cmd_rs, cmd_byte, busy, ac, err_busy, lcd_d_oe, lcd_d_out, disp_data} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: valid=%b rs=%b byte=%h busy=%b ac=%h err=%b oe=%b out=%h disp=%h required all 0",
               cmd_valid, cmd_rs, cmd_byte, busy, ac, err_busy, lcd_d_oe, lcd_d_out, disp_data);
    end
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
  endtask

  task automatic test_8bit_write();
    bus_write(1'b0, 4'h3);
    n_tests++;
    if (n_valid !== 1 || last_byte !== 8'h30 || last_rs !== 1'b0) begin
      n_fail++;
      $display("FAIL first_write: strobes=%0d byte=%h rs=%b required 1 30 0", n_valid, last_byte, last_rs);
    end
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_rise: busy=%b required 1", busy);
    end
    wait_not_busy();
    n_tests++;
    if (fall_cyc - valid_cyc !== BUSY) begin
      n_fail++;
      $display("FAIL busy_length: %0d cycles required %0d", fall_cyc - valid_cyc, BUSY);
    end
  endtask

  task automatic test_init_4bit();
    int n0;
    bus_write(1'b0, 4'h3); wait_not_busy();
    bus_write(1'b0, 4'h3); wait_not_busy();
    bus_write(1'b0, 4'h2); wait_not_busy();
    n_tests++;
    if (last_byte !== 8'h20) begin
      n_fail++;
      $display("FAIL func_set_4bit: byte=%h required 20", last_byte);
    end
    n0 = n_valid;
    bus_write(1'b0, 4'h2);
    n_tests++;
    if (n_valid !== n0) begin
      n_fail++;
      $display("FAIL hi_nibble_no_strobe: strobes=%0d required %0d", n_valid, n0);
    end
    bus_write(1'b0, 4'h8);
    n_tests++;
    if (n_valid !== n0 + 1 || last_byte !== 8'h28) begin
      n_fail++;
      $display("FAIL nibble_pair: strobes=%0d byte=%h required %0d 28", n_valid, last_byte, n0 + 1);
    end
    wait_not_busy();
  endtask

  task automatic test_data_write();
    bus_write(1'b1, 4'h5);
    bus_write(1'b1, 4'h2);
    n_tests++;
    if (last_byte !== 8'h52 || last_rs !== 1'b1 || ac !== 7'h01) begin
      n_fail++;
      $display("FAIL data_write: byte=%h rs=%b ac=%h required 52 1 01", last_byte, last_rs, ac);
    end
    wait_not_busy();
    disp_addr = 7'h05;
    repeat (2) @(negedge sys_clk);
    disp_addr = 7'h00;
    @(negedge sys_clk);
    n_tests++;
    if (disp_data !== 8'h52) begin
      n_fail++;
      $display("FAIL disp_latency: disp_data=%h required 52", disp_data);
    end
  endtask

  task automatic test_clear();
    int clr_cyc, n0, bad;
    bus_write(1'b0, 4'h0);
    bus_write(1'b0, 4'h1);
    clr_cyc = valid_cyc;
    n_tests++;
    if (last_byte !== 8'h01 || ac !== 7'h00 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL clear_exec: byte=%h ac=%h busy=%b required 01 00 1", last_byte, ac, busy);
    end
    n0 = n_valid;
    bus_write(1'b1, 4'h4);
    bus_write(1'b1, 4'h1);
    n_tests++;
    if (err_busy !== 1'b1 || n_valid !== n0 + 1 || last_byte !== 8'h41 || ac !== 7'h00) begin
      n_fail++;
      $display("FAIL write_while_busy: err=%b strobes=%0d byte=%h ac=%h required 1 %0d 41 00",
               err_busy, n_valid, last_byte, ac, n0 + 1);
    end
    wait_not_busy();
    n_tests++;
    if (fall_cyc - clr_cyc !== CLEAR) begin
      n_fail++;
      $display("FAIL clear_busy_length: %0d cycles required %0d", fall_cyc - clr_cyc, CLEAR);
    end
    bad = 0;
    for (int a = 0; a < 128; a++) begin
      disp_addr = 7'(a);
      @(negedge sys_clk);
      if (disp_data !== 8'h20) bad++;
    end
    n_tests++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL clear_sweep: %0d entries differ from 20 required 0", bad);
    end
  endtask

  task automatic test_wrap();
    bus_write(1'b0, 4'hF); bus_write(1'b0, 4'hF);
    n_tests++;
    if (ac !== 7'h7F) begin
      n_fail++;
      $display("FAIL set_ddram_addr: ac=%h required 7f", ac);
    end
    wait_not_busy();
    bus_write(1'b1, 4'h4); bus_write(1'b1, 4'h1);
    n_tests++;
    if (ac !== 7'h00) begin
      n_fail++;
      $display("FAIL ac_wrap_up: ac=%h required 00", ac);
    end
    wait_not_busy();
    bus_write(1'b0, 4'h0); bus_write(1'b0, 4'h4);
    wait_not_busy();
    bus_write(1'b1, 4'h6); bus_write(1'b1, 4'h1);
    n_tests++;
    if (ac !== 7'h7F) begin
      n_fail++;
      $display("FAIL ac_wrap_down: ac=%h required 7f", ac);
    end
    wait_not_busy();
    disp_addr = 7'h7F;
    @(negedge sys_clk);
    n_tests++;
    if (disp_data !== 8'h41) begin
      n_fail++;
      $display("FAIL ddram_7f: data=%h required 41", disp_data);
    end
    disp_addr = 7'h00;
    @(negedge sys_clk);
    n_tests++;
    if (disp_data !== 8'h61) begin
      n_fail++;
      $display("FAIL ddram_00: data=%h required 61", disp_data);
    end
  endtask

  task automatic test_read();
    logic [3:0] hi, lo;
    logic       oe_hi, oe_lo;
    bus_write(1'b0, 4'h8); bus_write(1'b0, 4'h0);
`ifdef HD44780_RSP_READ_EN
    bus_read(1'b0, hi, oe_hi);
    bus_read(1'b0, lo, oe_lo);
    n_tests++;
    if (hi !== 4'h8 || lo !== 4'h0 || oe_hi !== 1'b1 || oe_lo !== 1'b1) begin
      n_fail++;
      $display("FAIL read_busy_ac: hi=%h lo=%h oe=%b%b required 8 0 11", hi, lo, oe_hi, oe_lo);
    end
    n_tests++;
    if (lcd_d_oe !== 1'b0) begin
      n_fail++;
      $display("FAIL oe_release: oe=%b required 0", lcd_d_oe);
    end
    wait_not_busy();
    bus_read(1'b1, hi, oe_hi);
    bus_read(1'b1, lo, oe_lo);
    n_tests++;
    if (hi !== 4'h6 || lo !== 4'h1 || ac !== 7'h7F) begin
      n_fail++;
      $display("FAIL read_data: hi=%h lo=%h ac=%h required 6 1 7f", hi, lo, ac);
    end
`else
    wait_not_busy();
    bus_read(1'b1, hi, oe_hi);
    n_tests++;
    if (oe_hi !== 1'b0 || hi !== 4'h0 || ac !== 7'h00) begin
      n_fail++;
      $display("FAIL read_disabled: oe=%b out=%h ac=%h required 0 0 00", oe_hi, hi, ac);
    end
    bus_write(1'b0, 4'h8); bus_write(1'b0, 4'h5);
    n_tests++;
    if (last_byte !== 8'h85 || ac !== 7'h05) begin
      n_fail++;
      $display("FAIL read_no_phase: byte=%h ac=%h required 85 05", last_byte, ac);
    end
    lo = 4'h0; oe_lo = 1'b0;
`endif
  endtask

  task automatic test_reset_mid_clear();
    int n0;
    wait_not_busy();
    bus_write(1'b0, 4'h0); bus_write(1'b0, 4'h1);
    repeat (8) @(negedge sys_clk);
    sys_rst_n = 1'b0;
    @(negedge sys_clk);
    n_tests++;
    if (busy !== 1'b0 || ac !== 7'h00 || err_busy !== 1'b0 || cmd_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: busy=%b ac=%h err=%b valid=%b required 0 00 0 0", busy, ac, err_busy, cmd_valid);
    end
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
    n0 = n_valid;
    bus_write(1'b0, 4'h3);
    n_tests++;
    if (n_valid !== n0 + 1 || last_byte !== 8'h30) begin
      n_fail++;
      $display("FAIL reset_to_8bit: strobes=%0d byte=%h required %0d 30", n_valid, last_byte, n0 + 1);
    end
    disp_addr = 7'h7F;
    repeat (2) @(negedge sys_clk);
    n_tests++;
    if (disp_data !== 8'h41) begin
      n_fail++;
      $display("FAIL sweep_abort: ddram[7f]=%h required 41", disp_data);
    end
  endtask

  initial begin
    test_reset();
    test_8bit_write();
    test_init_4bit();
    test_data_write();
    test_clear();
    test_wrap();
    test_read();
    test_reset_mid_clear();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
